// File: rtl/div_io_seq.sv
// Byte-serial sequencer between the pad interface and the divider core: gathers two
// operands, starts the core, waits for completion or timeout, streams the result out.
module div_io_seq #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_in,
  input  logic [7:0]       data_in_in,
  input  logic             sign,
  input  logic             select,
  output logic             div_start,
  output logic             div_mode,
  output logic             div_sign,
  output logic [WIDTH-1:0] div_opa,
  output logic [WIDTH-1:0] div_opb,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quo,
  input  logic [WIDTH-1:0] div_rem,
  input  logic             div_sign_res,
  output logic [7:0]       data_out_out,
  output logic             sign_out,
  output logic             pull_out,
  output logic             busy,
  output logic             timeout_err
);

  localparam int NB     = WIDTH / 8;
  localparam int NBYTES = 2 * NB;
  localparam int CW     = $clog2(NBYTES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [TO_W-1:0]    timer;
  logic [2*WIDTH-1:0] ops;
  logic [2*WIDTH-1:0] ops_next;
  logic [2*WIDTH-1:0] res;
  logic [7:0]         send_byte;
  logic [CW-1:0]      send_total;
  logic               last_load;
  logic               timer_expired;

  assign div_opa = ops[WIDTH-1:0];
  assign div_opb = ops[2*WIDTH-1:WIDTH];

  // cnt is the byte index for both loading and sending; the loops keep every
  // part-select constant so the index width never has to match the vector width.
  always_comb begin
    ops_next  = ops;
    send_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt == CW'(i)) begin
        ops_next[i*8 +: 8] = data_in_in;
        send_byte          = res[i*8 +: 8];
      end
    end
  end

  assign send_total    = div_mode ? CW'(NB) : CW'(NBYTES);
  assign last_load     = (cnt == CW'(NBYTES - 1));
  assign timer_expired = (timer == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand and result registers are reset along with the control
      // state so an aborted load can never leak bytes into the next operation.
      state        <= S_IDLE;
      cnt          <= '0;
      timer        <= '0;
      ops          <= '0;
      res          <= '0;
      div_start    <= 1'b0;
      div_mode     <= 1'b0;
      div_sign     <= 1'b0;
      data_out_out <= 8'h00;
      sign_out     <= 1'b0;
      pull_out     <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // NOTE: default-low here makes div_start a single-cycle pulse without
      // needing an explicit clear in every state.
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (push_in) begin
            ops      <= ops_next;
            div_mode <= select;
            div_sign <= sign;
            cnt      <= CW'(1);
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (push_in) begin
            ops <= ops_next;
            if (last_load) begin
              cnt         <= '0;
              timer       <= '0;
              div_start   <= 1'b1;
              busy        <= 1'b1;
              timeout_err <= 1'b0;
              state       <= S_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_START: begin
          // Counting the START cycle puts the abort exactly TIMEOUT cycles after div_start.
          timer <= timer + 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            res          <= {div_rem, div_quo};
            data_out_out <= div_quo[7:0];
            sign_out     <= div_sign_res;
            pull_out     <= 1'b1;
            cnt          <= CW'(1);
            state        <= S_SEND;
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SEND: begin
          if (cnt == send_total) begin
            data_out_out <= 8'h00;
            sign_out     <= 1'b0;
            pull_out     <= 1'b0;
            busy         <= 1'b0;
            cnt          <= '0;
            state        <= S_IDLE;
          end else begin
            data_out_out <= send_byte;
            cnt          <= cnt + 1'b1;
          end
        end
        default: begin
          data_out_out <= 8'h00;
          sign_out     <= 1'b0;
          pull_out     <= 1'b0;
          busy         <= 1'b0;
          cnt          <= '0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_io_seq.sv
// Directed bench for div_io_seq: byte loading, core handshake, timeout, result streaming.
module tb_div_io_seq;

  localparam int W  = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_in;
  logic [7:0]    data_in_in;
  logic          sign;
  logic          select;
  logic          div_start;
  logic          div_mode;
  logic          div_sign;
  logic [W-1:0]  div_opa;
  logic [W-1:0]  div_opb;
  logic          div_done;
  logic [W-1:0]  div_quo;
  logic [W-1:0]  div_rem;
  logic          div_sign_res;
  logic [7:0]    data_out_out;
  logic          sign_out;
  logic          pull_out;
  logic          busy;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;

  div_io_seq #(.WIDTH(W), .TIMEOUT(TO), .TO_W(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_in      (push_in),
    .data_in_in   (data_in_in),
    .sign         (sign),
    .select       (select),
    .div_start    (div_start),
    .div_mode     (div_mode),
    .div_sign     (div_sign),
    .div_opa      (div_opa),
    .div_opb      (div_opb),
    .div_done     (div_done),
    .div_quo      (div_quo),
    .div_rem      (div_rem),
    .div_sign_res (div_sign_res),
    .data_out_out (data_out_out),
    .sign_out     (sign_out),
    .pull_out     (pull_out),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic load_bytes(input logic [63:0] v, input int n, input logic s, input logic sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_in    = 1'b1;
      data_in_in = v[i*8 +: 8];
      sign       = s;
      select     = sel;
    end
    @(negedge clk);
    push_in    = 1'b0;
    data_in_in = 8'h00;
  endtask

  task automatic check_start(input logic [63:0] v, input logic s, input logic sel, input string tag);
    checks++;
    if (div_start !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s start_pulse: div_start=%b busy=%b expected 1 1", tag, div_start, busy);
    end
    checks++;
    if (div_opa !== v[31:0] || div_opb !== v[63:32]) begin
      failures++;
      $display("FAIL %s operands: opa=%h opb=%h expected %h %h", tag, div_opa, div_opb, v[31:0], v[63:32]);
    end
    checks++;
    if (div_mode !== sel || div_sign !== s || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL %s latched_flags: mode=%b sign=%b terr=%b expected %b %b 0",
               tag, div_mode, div_sign, timeout_err, sel, s);
    end
    @(negedge clk);
    checks++;
    if (div_start !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s start_one_cycle: div_start=%b busy=%b expected 0 1", tag, div_start, busy);
    end
  endtask

  task automatic pulse_done(input logic [31:0] q, input logic [31:0] r, input logic sr,
                            input int delay, input string tag);
    repeat (delay) @(negedge clk);
    checks++;
    if (pull_out !== 1'b0) begin
      failures++;
      $display("FAIL %s pull_before_done: pull_out=%b expected 0", tag, pull_out);
    end
    div_done     = 1'b1;
    div_quo      = q;
    div_rem      = r;
    div_sign_res = sr;
    @(negedge clk);
    div_done     = 1'b0;
    div_quo      = 32'h0;
    div_rem      = 32'h0;
    div_sign_res = 1'b0;
  endtask

  task automatic run_send(input logic [63:0] exp, input int n, input logic sr, input string tag);
    for (int j = 0; j < n; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (pull_out !== 1'b1 || data_out_out !== exp[j*8 +: 8] || sign_out !== sr) begin
        failures++;
        $display("FAIL %s byte%0d: pull=%b data=%h sign=%b expected 1 %h %b",
                 tag, j, pull_out, data_out_out, sign_out, exp[j*8 +: 8], sr);
      end
    end
    @(negedge clk);
    checks++;
    if (pull_out !== 1'b0 || data_out_out !== 8'h00 || sign_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end_of_send: pull=%b data=%h sign=%b busy=%b expected 0 00 0 0",
               tag, pull_out, data_out_out, sign_out, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({div_start, div_mode, div_sign, div_opa, div_opb, data_out_out,
         sign_out, pull_out, busy, timeout_err} !== '0) begin
      failures++;
      $display("FAIL %s outputs_zero: start=%b mode=%b sign=%b opa=%h opb=%h data=%h so=%b pull=%b busy=%b terr=%b expected all 0",
               tag, div_start, div_mode, div_sign, div_opa, div_opb, data_out_out,
               sign_out, pull_out, busy, timeout_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push_in = 1'b0; data_in_in = 8'h00; sign = 1'b0; select = 1'b0;
    div_done = 1'b0; div_quo = '0; div_rem = '0; div_sign_res = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_divr2();
    load_bytes(64'h00000007_00000064, 8, 1'b0, 1'b0);
    check_start(64'h00000007_00000064, 1'b0, 1'b0, "divr2");
    pulse_done(32'd14, 32'd2, 1'b0, 2, "divr2");
    run_send(64'h00000002_0000000E, 8, 1'b0, "divr2");
  endtask

  task automatic test_fp32();
    load_bytes(64'h40000000_3F800000, 8, 1'b1, 1'b1);
    check_start(64'h40000000_3F800000, 1'b1, 1'b1, "fp32");
    pulse_done(32'h3F000000, 32'hDEADBEEF, 1'b1, 1, "fp32");
    run_send(64'h00000000_3F000000, 4, 1'b1, "fp32");
  endtask

  task automatic test_timeout();
    load_bytes(64'h00000007_00000064, 8, 1'b0, 1'b0);
    check_start(64'h00000007_00000064, 1'b0, 1'b0, "timeout");
    for (int i = 2; i < TO; i++) begin
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || pull_out !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL timeout wait_cycle%0d: terr=%b pull=%b busy=%b expected 0 0 1",
                 i, timeout_err, pull_out, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || pull_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout abort: terr=%b busy=%b pull=%b expected 1 0 0", timeout_err, busy, pull_out);
    end
    div_done = 1'b1;
    div_quo  = 32'hFFFFFFFF;
    @(negedge clk);
    div_done = 1'b0;
    div_quo  = 32'h0;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || pull_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout sticky_and_done_ignored: terr=%b pull=%b busy=%b expected 1 0 0",
               timeout_err, pull_out, busy);
    end
    load_bytes(64'h00000005_0000001F, 8, 1'b0, 1'b0);
    check_start(64'h00000005_0000001F, 1'b0, 1'b0, "timeout_recover");
    pulse_done(32'd6, 32'd1, 1'b0, 1, "timeout_recover");
    run_send(64'h00000001_00000006, 8, 1'b0, "timeout_recover");
  endtask

  task automatic test_push_ignored();
    load_bytes(64'h00000007_00000064, 8, 1'b0, 1'b0);
    check_start(64'h00000007_00000064, 1'b0, 1'b0, "push_ign");
    push_in    = 1'b1;
    data_in_in = 8'hFF;
    repeat (3) @(negedge clk);
    pulse_done(32'd14, 32'd2, 1'b0, 0, "push_ign");
    run_send(64'h00000002_0000000E, 8, 1'b0, "push_ign");
    push_in    = 1'b0;
    data_in_in = 8'h00;
    @(negedge clk);
    checks++;
    if (div_opa !== 32'h64 || div_opb !== 32'h7 || busy !== 1'b0 || pull_out !== 1'b0) begin
      failures++;
      $display("FAIL push_ign operands_kept: opa=%h opb=%h busy=%b pull=%b expected 00000064 00000007 0 0",
               div_opa, div_opb, busy, pull_out);
    end
  endtask

  task automatic test_reset_mid_load();
    load_bytes(64'h11223344_55667788, 5, 1'b1, 1'b1);
    checks++;
    if (div_opa !== 32'h55667788 || div_opb !== 32'h00000044 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midload partial: opa=%h opb=%h busy=%b expected 55667788 00000044 0",
               div_opa, div_opb, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midload_rst1");
    @(negedge clk);
    check_all_zero("midload_rst2");
    rst_n = 1'b1;
    @(negedge clk);
    load_bytes(64'h00000002_00000009, 8, 1'b0, 1'b0);
    check_start(64'h00000002_00000009, 1'b0, 1'b0, "midload_new");
    pulse_done(32'd4, 32'd1, 1'b0, 1, "midload_new");
    run_send(64'h00000001_00000004, 8, 1'b0, "midload_new");
  endtask

  task automatic test_done_at_timeout();
    load_bytes(64'h00000007_00000064, 8, 1'b0, 1'b0);
    check_start(64'h00000007_00000064, 1'b0, 1'b0, "done_at_to");
    pulse_done(32'd14, 32'd2, 1'b1, TO - 2, "done_at_to");
    checks++;
    if (timeout_err !== 1'b0 || pull_out !== 1'b1) begin
      failures++;
      $display("FAIL done_at_to race: terr=%b pull=%b expected 0 1", timeout_err, pull_out);
    end
    run_send(64'h00000002_0000000E, 8, 1'b1, "done_at_to");
  endtask

  initial begin
    test_reset();
    test_divr2();
    test_fp32();
    test_timeout();
    test_push_ignored();
    test_reset_mid_load();
    test_done_at_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
